// File: rtl/word_packer.sv
// word_packer: packs RATIO consecutive SIZEDATA-bit words into one wide beat with per-lane keep bits.
// Latency: a completing word accepted at edge N is presented with valid_o=1 in cycle N+1.
// Backpressure: ready_o follows ready_i combinationally while a beat is held; optional idle flush via WORD_PACKER_TIMEOUT_EN.
module word_packer #(
  parameter int SIZEDATA = 32,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [SIZEDATA-1:0]       data_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [SIZEDATA*RATIO-1:0] data_o,
  output logic [RATIO-1:0]          keep_o,
  output logic                      last_o,
  input  logic                      ready_i
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  // Assembly holds lanes 0..RATIO-2; the final lane goes straight to the output register.
  localparam int AL = (RATIO > 1) ? RATIO - 1 : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  if (RATIO < 1 || TIMEOUT < 1) begin : g_param_check
    $error("word_packer: RATIO and TIMEOUT must be >= 1");
  end

  logic [CW-1:0]              cnt;
  logic [SIZEDATA-1:0]        asm_data [AL];
  logic [AL-1:0]              asm_keep;
  logic                       accept;
  logic                       complete;
  logic                       out_xfer;
  logic                       flush;
  logic [SIZEDATA*RATIO-1:0]  beat_data;
  logic [RATIO-1:0]           beat_keep;

  // The output register is always free when a word is accepted.
  assign ready_o  = !rst_i && (!valid_o || ready_i);
  assign accept   = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;
  assign complete = accept && (last_i || cnt == LAST_LANE);

  // Candidate beat: assembled lanes plus the incoming word in lane cnt; unfilled lanes stay zero.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      beat_data[k*SIZEDATA +: SIZEDATA] = asm_data[k];
      beat_keep[k]                      = asm_keep[k];
    end
    if (accept) begin
      for (int k = 0; k < RATIO; k++) begin
        if (cnt == CW'(k)) begin
          beat_data[k*SIZEDATA +: SIZEDATA] = data_i;
          beat_keep[k]                      = 1'b1;
        end
      end
    end
  end

`ifdef WORD_PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle;

  // Count idle cycles while a partial beat is waiting; saturate at TIMEOUT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle <= '0;
    end else if (accept) begin
      idle <= '0;
    end else if (cnt != '0 && idle != IW'(TIMEOUT)) begin
      idle <= idle + 1'b1;
    end
  end

  // A word arriving in the same cycle takes priority over the flush.
  assign flush = !accept && (cnt != '0) && (idle == IW'(TIMEOUT)) && (!valid_o || ready_i);
`else
  assign flush = 1'b0;
`endif

  // Output register and lane assembly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      data_o   <= '0;
      keep_o   <= '0;
      last_o   <= 1'b0;
      cnt      <= '0;
      asm_keep <= '0;
      for (int k = 0; k < AL; k++) asm_data[k] <= '0;
    end else if (complete || flush) begin
      data_o   <= beat_data;
      keep_o   <= beat_keep;
      last_o   <= complete && last_i;
      valid_o  <= 1'b1;
      cnt      <= '0;
      asm_keep <= '0;
      for (int k = 0; k < AL; k++) asm_data[k] <= '0;
    end else begin
      if (out_xfer) valid_o <= 1'b0;
      if (accept) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (cnt == CW'(k)) begin
            asm_data[k] <= data_i;
            asm_keep[k] <= 1'b1;
          end
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
